// File: rtl/fifo_rd_ctrl_lvl_pkg.sv
// Shared FIFO pointer helpers for the read and write control blocks.
// Holds the default geometry and the Gray/binary conversion functions.
// Optional feature macro used by the read block: FIFO_RD_UNDERFLOW_EN.
package fifo_rd_ctrl_lvl_pkg;

  localparam int unsigned ADDR_SIZE_DFLT  = 3;
  localparam int unsigned AEMPTY_LVL_DFLT = 1;

  // Zero-extended operands keep both functions exact for any pointer width up to 32.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    logic        acc;
    bin = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      acc         = acc ^ gray[31 - i];
      bin[31 - i] = acc;
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_lvl_if.sv
// Read-side FIFO control bundle: request, synchronised write pointer and
// everything the read controller reports back.
// master = read controller, slave = consumer / RAM / write-side synchroniser.
interface fifo_rd_ctrl_lvl_if
  import fifo_rd_ctrl_lvl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DFLT
);

  logic                 rinc;
  logic [ADDR_SIZE:0]   rq2_wptr;
  logic [ADDR_SIZE:0]   rptr;
  logic [ADDR_SIZE-1:0] raddr;
  logic                 rempty;
  logic                 raempty;
  logic [ADDR_SIZE:0]   rlevel;
  logic                 runderflow;

  modport master (
    input  rinc, rq2_wptr,
    output rptr, raddr, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    output rinc, rq2_wptr,
    input  rptr, raddr, rempty, raempty, rlevel, runderflow
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Width-parametrised Gray-to-binary decoder, purely combinational.
// Shared by the read- and write-side level logic.
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // MSB-down XOR chain: each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      acc              = acc ^ gray[W - 1 - i];
      bin[W - 1 - i]   = acc;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl_lvl.sv
// Read-domain FIFO control: binary/Gray read pointer, empty and almost-empty
// flags and a registered occupancy count, all in the rclk domain.
// Optional sticky underflow flag enabled by defining FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ctrl_lvl
  import fifo_rd_ctrl_lvl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DFLT,
  parameter int unsigned AEMPTY_LVL = AEMPTY_LVL_DFLT
) (
  input logic               rclk,
  input logic               rrst_n,
  fifo_rd_ctrl_lvl_if.master bus
);

  localparam int unsigned      PTR_W  = ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AEMPTY_LVL);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rgray;
  logic             rempty_q;
  logic             raempty_q;
  logic [PTR_W-1:0] rlevel_q;

  logic             rd_en;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] lvl_next;

  fifo_gray2bin #(.W(PTR_W)) u_wptr_dec (
    .gray (bus.rq2_wptr),
    .bin  (wbin)
  );

  // Next pointer and level; the level uses the post-read pointer so a read and
  // a write-pointer advance in the same cycle are both reflected in one update.
  always_comb begin
    rd_en      = bus.rinc & ~rempty_q;
    rbin_next  = rbin + PTR_W'(rd_en);
    rgray_next = PTR_W'(bin2gray(32'(rbin_next)));
    lvl_next   = wbin - rbin_next;
  end

  // Pointer and flag registers.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rgray     <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rlevel_q  <= '0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      rempty_q  <= (rgray_next == bus.rq2_wptr);
      raempty_q <= (lvl_next <= AE_LVL);
      rlevel_q  <= lvl_next;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic runderflow_q;

  // Sticky record of any read attempted while empty; only reset clears it.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      runderflow_q <= 1'b0;
    end else if (bus.rinc && rempty_q) begin
      runderflow_q <= 1'b1;
    end
  end

  assign bus.runderflow = runderflow_q;
`else
  assign bus.runderflow = 1'b0;
`endif

  assign bus.rptr    = rgray;
  assign bus.raddr   = rbin[ADDR_SIZE-1:0];
  assign bus.rempty  = rempty_q;
  assign bus.raempty = raempty_q;
  assign bus.rlevel  = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_ctrl_lvl.sv
// Self-checking bench for fifo_rd_ctrl_lvl (ADDR_SIZE=3, AEMPTY_LVL=1).
// Reference model counts reads and writes as plain integers; the level is
// their difference and all pointers are derived from those counts.
module tb_fifo_rd_ctrl_lvl;

  localparam int unsigned AS  = 3;
  localparam int unsigned AEL = 1;
`ifdef FIFO_RD_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  fifo_rd_ctrl_lvl_if #(.ADDR_SIZE(AS)) bus ();

  fifo_rd_ctrl_lvl #(.ADDR_SIZE(AS), .AEMPTY_LVL(AEL)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  // Model state: total reads accepted, total writes visible, last level.
  int m_rd  = 0;
  int m_wr  = 0;
  int m_lvl = 0;
  bit m_uf  = 1'b0;

  typedef struct {
    bit         rinc;
    int         wcnt;
    int         lvl;
    bit         empty;
    bit         aempty;
    int         raddr;
    logic [3:0] rptr;
    bit         uf;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [3:0] gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, advance the model, settle.
  task automatic tick(input bit rinc, input int wcnt, input bit rst_n);
    @(negedge rclk);
    bus.rinc     = rinc;
    bus.rq2_wptr = gray(wcnt);
    rrst_n       = rst_n;
    @(posedge rclk);
    m_wr = wcnt;
    if (!rst_n) begin
      m_rd  = 0;
      m_lvl = 0;
      m_uf  = 1'b0;
    end else begin
      if (rinc && m_lvl == 0) m_uf = 1'b1;
      if (rinc && m_lvl != 0) m_rd++;
      m_lvl = m_wr - m_rd;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rlevel"},     32'(bus.rlevel),     32'(m_lvl));
    check({tag, ".rempty"},     32'(bus.rempty),     32'(m_lvl == 0));
    check({tag, ".raempty"},    32'(bus.raempty),    32'(m_lvl <= int'(AEL)));
    check({tag, ".raddr"},      32'(bus.raddr),      32'(m_rd % 8));
    check({tag, ".rptr"},       32'(bus.rptr),       32'(gray(m_rd)));
    check({tag, ".runderflow"}, 32'(bus.runderflow), 32'(m_uf & UF_EN));
  endtask

  initial begin
    logic [3:0]  prev_ptr;
    logic [15:0] seen;
    int          room;
    int          jump;
    bit          rinc;

    vecs[0] = '{0, 3, 3, 0, 0, 0, 4'b0000, 0};  // fill view
    vecs[1] = '{1, 3, 2, 0, 0, 1, 4'b0001, 0};  // drain
    vecs[2] = '{1, 3, 1, 0, 1, 2, 4'b0011, 0};
    vecs[3] = '{1, 3, 0, 1, 1, 3, 4'b0010, 0};
    vecs[4] = '{1, 3, 0, 1, 1, 3, 4'b0010, 1};  // read while empty
    vecs[5] = '{0, 5, 2, 0, 0, 3, 4'b0010, 1};
    vecs[6] = '{1, 7, 3, 0, 0, 4, 4'b0110, 1};  // write jump 5->7 with read

    bus.rinc     = 1'b1;
    bus.rq2_wptr = 4'b0110;

    // Reset held two edges with a pending read and a nonzero write pointer.
    tick(1'b1, 4, 1'b0);
    tick(1'b1, 4, 1'b0);
    check("rst.rptr",       32'(bus.rptr),       32'd0);
    check("rst.raddr",      32'(bus.raddr),      32'd0);
    check("rst.rempty",     32'(bus.rempty),     32'd1);
    check("rst.raempty",    32'(bus.raempty),    32'd1);
    check("rst.rlevel",     32'(bus.rlevel),     32'd0);
    check("rst.runderflow", 32'(bus.runderflow), 32'd0);

    // Release between edges: nothing moves until the next edge.
    @(negedge rclk);
    rrst_n = 1'b1;
    #2;
    check("rel.rlevel", 32'(bus.rlevel), 32'd0);
    check("rel.rempty", 32'(bus.rempty), 32'd1);

    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].rinc, vecs[i].wcnt, 1'b1);
      check($sformatf("vec%0d.rlevel", i),     32'(bus.rlevel),     32'(vecs[i].lvl));
      check($sformatf("vec%0d.rempty", i),     32'(bus.rempty),     32'(vecs[i].empty));
      check($sformatf("vec%0d.raempty", i),    32'(bus.raempty),    32'(vecs[i].aempty));
      check($sformatf("vec%0d.raddr", i),      32'(bus.raddr),      32'(vecs[i].raddr));
      check($sformatf("vec%0d.rptr", i),       32'(bus.rptr),       32'(vecs[i].rptr));
      check($sformatf("vec%0d.runderflow", i), 32'(bus.runderflow), 32'(vecs[i].uf & UF_EN));
      check_model($sformatf("vec%0d.model", i));
    end

    // Asserting reset between edges does not disturb outputs before the edge.
    @(negedge rclk);
    rrst_n = 1'b0;
    #2;
    check("midrst.rlevel", 32'(bus.rlevel), 32'd3);
    check("midrst.raddr",  32'(bus.raddr),  32'd4);
    tick(1'b0, 0, 1'b0);
    check_model("midrst.after");

    // Full view, then two laps of continuous reads with the writer ahead.
    tick(1'b0, 8, 1'b1);
    check("full.rlevel", 32'(bus.rlevel), 32'd8);
    check("full.rempty", 32'(bus.rempty), 32'd0);
    check_model("full");
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      prev_ptr = bus.rptr;
      tick(1'b1, m_rd + 8, 1'b1);
      check_model($sformatf("wrap%0d", i));
      check($sformatf("wrap%0d.gray_step", i), 32'($countones(prev_ptr ^ bus.rptr)), 32'd1);
      seen[bus.rptr] = 1'b1;
    end
    check("wrap.all_codes", 32'(seen), 32'hFFFF);

    // Randomised traffic: writer respects full, jumps up to the free space.
    tick(1'b0, 0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rinc = 1'($urandom_range(0, 1));
      room = 8 - (m_wr - m_rd);
      jump = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, room));
      if ($urandom_range(0, 79) == 0) begin
        tick(rinc, 0, 1'b0);
      end else begin
        tick(rinc, m_wr + jump, 1'b1);
      end
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl_lvl.md
Name: fifo_rd_ctrl_lvl

Overview:
Read-domain control for the async FIFO, next generation of the read-pointer block. Keeps the binary/Gray read pointer and the empty flag. Adds:
- a registered occupancy count (rlevel);
- a parametrised almost-empty flag;
- an optional sticky underflow flag.

Sits in the rclk domain. Consumes the 2-flop-synchronised write pointer and drives the RAM read address and the Gray pointer back to the write-side synchroniser.

Parameters:
- ADDR_SIZE, 3, RAM address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- AEMPTY_LVL, 1, raempty asserts when occupancy <= AEMPTY_LVL; legal range 0..2^ADDR_SIZE-1.

Ports:
- rclk  in  1  read clock; all state on rising edge.
- rrst_n  in  1  reset, synchronous, active-low; sampled on rising edge of rclk only.
- rinc  in  1  read request; honoured only when rempty=0.
- rq2_wptr  in  ADDR_SIZE+1  synchronised write pointer, Gray code.
- rptr  out  ADDR_SIZE+1  read pointer, Gray code, registered.
- raddr  out  ADDR_SIZE  RAM read address = low bits of the binary read pointer.
- rempty  out  1  FIFO empty, registered.
- raempty  out  1  almost empty, registered.
- rlevel  out  ADDR_SIZE+1  occupancy as seen from the read domain, 0..2^ADDR_SIZE, registered.
- runderflow  out  1  sticky underflow flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rrst_n=0 at a rising edge): rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Deasserting or asserting rrst_n between edges has no effect until the next edge.
- Read acceptance: rd_en = rinc & ~rempty.
- Next-pointer logic:
  - rbin_next = rbin + rd_en, modulo 2^(ADDR_SIZE+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
- Write-pointer decode: wbin = gray2bin(rq2_wptr), combinational, MSB-down XOR chain.
- Level: lvl_next = (wbin - rbin_next) modulo 2^(ADDR_SIZE+1), full ADDR_SIZE+1-bit width, no saturation.
- Registered updates, every non-reset edge:
  - rbin <= rbin_next; rptr <= rgray_next;
  - rempty <= (rgray_next == rq2_wptr);
  - rlevel <= lvl_next;
  - raempty <= (lvl_next <= AEMPTY_LVL).
- Latency: a read accepted at edge N moves raddr, rptr, rempty, rlevel and raempty at edge N. RAM data for the new raddr is the RAM's concern.
- Invariants:
  - rempty=1 iff rlevel=0.
  - raempty=1 whenever rempty=1.
  - rlevel never exceeds 2^ADDR_SIZE while the write side respects full.
- Read while empty: ignored. Pointer, raddr and rlevel hold.
- Simultaneous read and write-pointer advance: the level reflects both in the same update. rq2_wptr may jump by more than 1 per rclk cycle (rclk slower than wclk); decode is exact for any jump up to depth.
- Wrap-around: rbin wraps 2^(ADDR_SIZE+1)-1 -> 0. raddr wraps 2^ADDR_SIZE-1 -> 0. The MSB difference keeps the full level (2^ADDR_SIZE) distinct from empty.
- No FSM beyond the pointer register. The block is purely a counter, comparator and flag pipeline.

Optional Feature:
- Macro: FIFO_RD_UNDERFLOW_EN.
- Defined:
  - runderflow <= 1 at any edge with rinc=1 and rempty=1.
  - Sticky; cleared only by reset.
  - Pointer behaviour is unchanged (the read is still ignored).
- Undefined: runderflow is tied to 1'b0; no extra flop is inferred.

Decomposition:
- Shared include (fifo_defs.vh), also used by the write side:
  - functions bin2gray and gray2bin, parametrised by pointer width;
  - pointer-width constant PTR_W = ADDR_SIZE+1.
- One natural sub-module: fifo_gray2bin (pure combinational, width-parametrised), reused by the write-side level logic.
- Everything else stays in fifo_rd_ctrl_lvl.

Test Plan (ADDR_SIZE=3, AEMPTY_LVL=1):
1. Reset: rrst_n=0 for 2 edges, with rinc=1 and rq2_wptr=4'b0110 -> rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Release between edges -> no change before the next edge.
2. Fill view: rq2_wptr=gray(3)=4'b0010, rinc=0 -> after 1 edge: rlevel=3, rempty=0, raempty=0.
3. Drain: then rinc=1 for 3 edges -> raddr 1,2,3; rlevel 2,1,0; raempty=1 from rlevel=1; rempty=1 with rlevel=0; final rptr=gray(3)=4'b0010.
4. Full and wrap: rbin=0, rq2_wptr=gray(8)=4'b1100 -> rlevel=8, rempty=0. Continuous read with the write pointer kept ahead over two laps -> raddr 7->0 wrap, rptr walks all 16 Gray codes with single-bit changes; rbin 15->0 wrap gives a correct level.
5. Multi-step write jump: rq2_wptr jumps gray(5)->gray(7) while rinc=1 at rlevel=2 -> next rlevel=3.
6. Underflow: rempty=1, rinc=1 for 1 edge -> raddr and rptr hold. With FIFO_RD_UNDERFLOW_EN: runderflow=1, stays 1 through later normal reads until reset. Without the macro: runderflow stays 0.
